// File: rtl/ss_display_scheduler_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Holds the FSM state encoding, the display word type and the digit-slice helper.
package ss_display_scheduler_pkg;

    // Display source: local board state or a held remote word
    typedef enum logic {
        S_LOCAL  = 1'b0,
        S_REMOTE = 1'b1
    } state_e;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned WORD_W     = DIGIT_W * NUM_DIGITS;

    // [3:0] = digit0 ... [15:12] = digit3
    typedef logic [WORD_W-1:0] disp_word_t;

    // Extract one display digit from a packed display word
    function automatic logic [DIGIT_W-1:0] digit_of(input disp_word_t w, input int unsigned idx);
        return w[idx*DIGIT_W +: DIGIT_W];
    endfunction

    // Counter width able to hold n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ss_hold_timer.sv
// Loadable down-counter used for the remote hold window and the blink half-period.
// expire is high while the counter is running and has reached zero; the counter
// stops by itself after expiry unless it is reloaded in that same cycle.
module ss_hold_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;
    logic             r_running;

    // Count down from the loaded value; clear wins over load
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (clear) begin
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (load) begin
            r_count   <= load_value;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (r_count == '0) begin
                r_running <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign expire = r_running && (r_count == '0);

endmodule

// File: rtl/ss_display_scheduler.sv
// Chooses the 16-bit value shown on the 4-digit seven-segment display.
// A remote word preempts the local shadow value for HOLD_CYCLES clocks; one further
// remote word may wait in a single pending slot. remote_clr aborts the remote display.
// Optional feature macro: DISP_BLINK_EN (blink disp_on while a remote word is held).
module ss_display_scheduler
    import ss_display_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        local_load,
    input  logic [15:0] local_value,
    input  logic        remote_valid,
    output logic        remote_ready,
    input  logic [15:0] remote_value,
    input  logic        remote_clr,
    output logic [3:0]  number0,
    output logic [3:0]  number1,
    output logic [3:0]  number2,
    output logic [3:0]  number3,
    output logic        src_remote,
    output logic        overflow,
    output logic        disp_on
);

    localparam int unsigned    HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_check
        $error("ss_display_scheduler: HOLD_CYCLES must be >= 2 and BLINK_CYCLES >= 1");
    end

    state_e     r_state;
    disp_word_t r_shadow;
    disp_word_t r_pending;
    logic       r_pending_full;
    disp_word_t r_number;
    logic       r_src_remote;
    logic       r_overflow;

    state_e     w_state_next;
    disp_word_t w_shadow_next;
    disp_word_t w_pending_next;
    logic       w_pending_full_next;
    disp_word_t w_number_next;
    logic       w_src_remote_next;
    logic       w_overflow_next;
    logic       w_ready;
    logic       w_accept;
    logic       w_hold_load;
    logic       w_hold_clear;
    logic       w_hold_expire;

    // A word is taken only when the slot can absorb it and no abort is in progress
    assign w_ready  = !r_pending_full && !remote_clr;
    assign w_accept = remote_valid && w_ready;

    ss_hold_timer #(
        .WIDTH (HOLD_W)
    ) u_hold_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_hold_load),
        .clear      (w_hold_clear),
        .load_value (HOLD_LOAD),
        .expire     (w_hold_expire)
    );

    // Next-state and datapath decisions; remote_clr overrides everything else
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_next        = r_state;
        w_pending_next      = r_pending;
        w_pending_full_next = r_pending_full;
        w_number_next       = r_number;
        w_src_remote_next   = r_src_remote;
        w_hold_load         = 1'b0;
        w_hold_clear        = 1'b0;
        // Forward a same-cycle local_load so a return to local never shows a stale shadow
        w_shadow_next       = local_load ? local_value : r_shadow;
        w_overflow_next     = r_overflow || (remote_valid && !w_ready && !remote_clr);

        if (remote_clr) begin
            w_pending_full_next = 1'b0;
            w_number_next       = w_shadow_next;
            w_src_remote_next   = 1'b0;
            w_state_next        = S_LOCAL;
            w_hold_clear        = 1'b1;
        end else begin
            case (r_state)
                S_LOCAL: begin
                    if (w_accept) begin
                        w_number_next     = remote_value;
                        w_src_remote_next = 1'b1;
                        w_hold_load       = 1'b1;
                        w_state_next      = S_REMOTE;
                    end else if (local_load) begin
                        w_number_next = local_value;
                    end
                end
                S_REMOTE: begin
                    if (w_hold_expire) begin
                        if (r_pending_full) begin
                            w_number_next       = r_pending;
                            w_pending_full_next = 1'b0;
                            w_hold_load         = 1'b1;
                        end else if (w_accept) begin
                            w_number_next = remote_value;
                            w_hold_load   = 1'b1;
                        end else begin
                            w_number_next     = w_shadow_next;
                            w_src_remote_next = 1'b0;
                            w_state_next      = S_LOCAL;
                        end
                    end else if (w_accept) begin
                        w_pending_next      = remote_value;
                        w_pending_full_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_LOCAL;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_LOCAL;
            r_shadow       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_number       <= '0;
            r_src_remote   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_shadow       <= w_shadow_next;
            r_pending      <= w_pending_next;
            r_pending_full <= w_pending_full_next;
            r_number       <= w_number_next;
            r_src_remote   <= w_src_remote_next;
            r_overflow     <= w_overflow_next;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned        BLINK_W    = cnt_width(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

    logic r_disp_on;
    logic w_disp_on_next;
    logic w_blink_load;
    logic w_blink_clear;
    logic w_blink_expire;

    ss_hold_timer #(
        .WIDTH (BLINK_W)
    ) u_blink_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_blink_load),
        .clear      (w_blink_clear),
        .load_value (BLINK_LOAD),
        .expire     (w_blink_expire)
    );

    // Blink phase restarts lit on every hold (re)load; solid on while local
    always_comb begin
        w_disp_on_next = r_disp_on;
        w_blink_load   = 1'b0;
        w_blink_clear  = 1'b0;
        if (w_state_next == S_LOCAL) begin
            w_disp_on_next = 1'b1;
            w_blink_clear  = 1'b1;
        end else if (w_hold_load) begin
            w_disp_on_next = 1'b1;
            w_blink_load   = 1'b1;
        end else if (w_blink_expire) begin
            w_disp_on_next = !r_disp_on;
            w_blink_load   = 1'b1;
        end
    end

    // Display-enable register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp_on <= 1'b1;
        end else begin
            r_disp_on <= w_disp_on_next;
        end
    end

    assign disp_on = r_disp_on;
`else
    assign disp_on = 1'b1;
`endif

    assign remote_ready = w_ready;
    assign src_remote   = r_src_remote;
    assign overflow     = r_overflow;
    assign number0      = digit_of(r_number, 0);
    assign number1      = digit_of(r_number, 1);
    assign number2      = digit_of(r_number, 2);
    assign number3      = digit_of(r_number, 3);

endmodule

// File: tb/tb_ss_display_scheduler.sv
// Directed bench for ss_display_scheduler with HOLD_CYCLES=8, BLINK_CYCLES=2.
// Expected outputs are queued as each step is driven and compared after the edge.
module tb_ss_display_scheduler;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned BLINK = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        local_load;
    logic [15:0] local_value;
    logic        remote_valid;
    logic        remote_ready;
    logic [15:0] remote_value;
    logic        remote_clr;
    logic [3:0]  number0, number1, number2, number3;
    logic        src_remote;
    logic        overflow;
    logic        disp_on;

    typedef struct {
        string       tag;
        logic [15:0] num;
        logic        src;
        logic        rdy;
        logic        ovf;
        logic        dsp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ss_display_scheduler #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .local_load   (local_load),
        .local_value  (local_value),
        .remote_valid (remote_valid),
        .remote_ready (remote_ready),
        .remote_value (remote_value),
        .remote_clr   (remote_clr),
        .number0      (number0),
        .number1      (number1),
        .number2      (number2),
        .number3      (number3),
        .src_remote   (src_remote),
        .overflow     (overflow),
        .disp_on      (disp_on)
    );

    always #5 clock = ~clock;

    // Expected disp_on k cycles after a hold (re)load
    function automatic logic exp_disp(int k);
        logic d = 1'b1;
`ifdef DISP_BLINK_EN
        d = ((k / BLINK) % 2) == 0;
`endif
        return d;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(string tag, logic [15:0] num, logic src, logic rdy, logic ovf, logic dsp);
        exp_t e;
        e.tag = tag; e.num = num; e.src = src; e.rdy = rdy; e.ovf = ovf; e.dsp = dsp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "_num"}, {number3, number2, number1, number0}, e.num);
            check({e.tag, "_src"}, 16'(src_remote), 16'(e.src));
            check({e.tag, "_rdy"}, 16'(remote_ready), 16'(e.rdy));
            check({e.tag, "_ovf"}, 16'(overflow), 16'(e.ovf));
            check({e.tag, "_dsp"}, 16'(disp_on), 16'(e.dsp));
        end
    endtask

    // One clock: inputs return to idle after the edge, then queued expectations are compared
    task automatic tick();
        @(posedge clock);
        #1;
        local_load   = 1'b0;
        remote_valid = 1'b0;
        remote_clr   = 1'b0;
        #1;
        drain();
    endtask

    task automatic offer(logic [15:0] v);
        remote_valid = 1'b1;
        remote_value = v;
    endtask

    task automatic hold_run(string tag, logic [15:0] v, int k_lo, int k_hi, logic rdy, logic ovf);
        for (int k = k_lo; k <= k_hi; k++) begin
            expect_out($sformatf("%s_k%0d", tag, k), v, 1'b1, rdy, ovf, exp_disp(k));
            tick();
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset        = 1'b1;
        local_load   = 1'b0;
        local_value  = '0;
        remote_valid = 1'b0;
        remote_value = '0;
        remote_clr   = 1'b0;
        #12;
        expect_out("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        reset = 1'b0;

        // 1: local value shows one edge after the strobe
        local_load = 1'b1; local_value = 16'hA842;
        expect_out("t1_local", 16'hA842, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        // 2: remote word preempts for HOLD cycles, then local returns
        offer(16'h1234);
        expect_out("t2_k0", 16'h1234, 1'b1, 1'b1, 1'b0, exp_disp(0));
        tick();
        hold_run("t2", 16'h1234, 1, 7, 1'b1, 1'b0);
        expect_out("t2_revert", 16'hA842, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        // 3: pending slot fills, a further word is refused and flagged
        offer(16'h1111);
        expect_out("t3_k0", 16'h1111, 1'b1, 1'b1, 1'b0, exp_disp(0));
        tick();
        offer(16'h5678);
        expect_out("t3_k1_pend", 16'h1111, 1'b1, 1'b0, 1'b0, exp_disp(1));
        tick();
        offer(16'h9999);
        expect_out("t3_k2_refuse", 16'h1111, 1'b1, 1'b0, 1'b1, exp_disp(2));
        tick();
        hold_run("t3a", 16'h1111, 3, 7, 1'b0, 1'b1);
        expect_out("t3_pend_out", 16'h5678, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t3b", 16'h5678, 1, 7, 1'b1, 1'b1);
        expect_out("t3_revert", 16'hA842, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // 4: word offered exactly on the expiry cycle bypasses the slot
        offer(16'h2222);
        expect_out("t4_k0", 16'h2222, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t4a", 16'h2222, 1, 7, 1'b1, 1'b1);
        offer(16'hBEEF);
        expect_out("t4_bypass", 16'hBEEF, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t4b", 16'hBEEF, 1, 7, 1'b1, 1'b1);
        expect_out("t4_revert", 16'hA842, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // 5: remote_clr mid-hold flushes the pending word and refuses the offered one
        offer(16'h3333);
        expect_out("t5_k0", 16'h3333, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        offer(16'h4444);
        expect_out("t5_k1_pend", 16'h3333, 1'b1, 1'b0, 1'b1, exp_disp(1));
        tick();
        hold_run("t5", 16'h3333, 2, 3, 1'b0, 1'b1);
        remote_clr = 1'b1;
        offer(16'h5555);
        expect_out("t5_clr", 16'hA842, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("t5_after%0d", i), 16'hA842, 1'b0, 1'b1, 1'b1, 1'b1);
            tick();
        end

        // 7a: local_load together with a remote accept updates the shadow only
        offer(16'h6666);
        local_load = 1'b1; local_value = 16'h0F0F;
        expect_out("t7a_k0", 16'h6666, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t7a", 16'h6666, 1, 7, 1'b1, 1'b1);
        expect_out("t7a_revert", 16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // 7b: local_load during a hold leaves the display alone
        offer(16'h7777);
        expect_out("t7b_k0", 16'h7777, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t7b", 16'h7777, 1, 2, 1'b1, 1'b1);
        local_load = 1'b1; local_value = 16'h1357;
        expect_out("t7b_k3_load", 16'h7777, 1'b1, 1'b1, 1'b1, exp_disp(3));
        tick();
        hold_run("t7b", 16'h7777, 4, 7, 1'b1, 1'b1);
        expect_out("t7b_revert", 16'h1357, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // 6: reset asserted mid-hold returns everything asynchronously
        offer(16'h8888);
        expect_out("t6_k0", 16'h8888, 1'b1, 1'b1, 1'b1, exp_disp(0));
        tick();
        hold_run("t6", 16'h8888, 1, 3, 1'b1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        expect_out("t6_async_rst", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("t6_idle%0d", i), 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        local_load = 1'b1; local_value = 16'hC0DE;
        expect_out("t6_local", 16'hC0DE, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
